// File: rtl/lcd_sched_pkg.sv
// lcd_sched_pkg: shared types and constants for the LCD pattern scheduler.
// Optional build macro used by this slice: LCD_SCHED_FRAME_CNT_EN
// (adds a free-running 16-bit frame counter output).
package lcd_sched_pkg;

  // Configuration modes as presented on cfg_mode.
  typedef enum logic [1:0] {
    AUTO   = 2'd0,
    FIXED  = 2'd1,
    SCROLL = 2'd2,
    BLANK  = 2'd3
  } cfg_mode_t;

  // Scheduler state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } sched_state_t;

  // Frames per step after reset.
  localparam int DEFAULT_RATE = 60;

  // A requested rate of zero would never step; treat it as one frame.
  function automatic logic [7:0] norm_rate(input logic [7:0] rate);
    return (rate == 8'd0) ? 8'd1 : rate;
  endfunction

endpackage

// File: rtl/lcd_pattern_sched_if.sv
// lcd_pattern_sched_if: valid/ready configuration port of the scheduler.
// The master side requests a new configuration; the slave is the scheduler.
interface lcd_pattern_sched_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_mode;
  logic [1:0] cfg_pattern;
  logic [7:0] cfg_rate;

  modport master (
    output cfg_valid,
    output cfg_mode,
    output cfg_pattern,
    output cfg_rate,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_mode,
    input  cfg_pattern,
    input  cfg_rate,
    output cfg_ready
  );
endinterface

// File: rtl/lcd_frame_tick.sv
// lcd_frame_tick: turns the active-low VSYNC into a one-cycle frame_tick.
// With LCD_SCHED_FRAME_CNT_EN defined it also counts every frame start.
module lcd_frame_tick (
  input  logic        PixelClk,
  input  logic        nRST,
  input  logic        LCD_VSYNC,
`ifdef LCD_SCHED_FRAME_CNT_EN
  output logic [15:0] frame_count,
`endif
  output logic        frame_tick
);

  // vs_q starts low so a VSYNC already low at reset release is not an edge.
  logic vs_q;
  logic frame_tick_reg;

  // Delay VSYNC one cycle and register its 1->0 transition as the tick.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      vs_q           <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      vs_q           <= LCD_VSYNC;
      frame_tick_reg <= vs_q & ~LCD_VSYNC;
    end
  end

  assign frame_tick = frame_tick_reg;

`ifdef LCD_SCHED_FRAME_CNT_EN
  logic [15:0] frame_count_reg;

  // Free-running frame counter, wraps naturally at 16 bits.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      frame_count_reg <= 16'd0;
    end else if (frame_tick_reg) begin
      frame_count_reg <= frame_count_reg + 16'd1;
    end
  end

  assign frame_count = frame_count_reg;
`endif

endmodule

// File: rtl/lcd_pattern_sched.sv
// lcd_pattern_sched: frame-synchronous scheduler for the colour-bar generator.
// Steps pattern_sel / bar_offset every N frames and applies new configuration
// only at frame starts. Optional macro LCD_SCHED_FRAME_CNT_EN adds frame_count.
module lcd_pattern_sched
  import lcd_sched_pkg::*;
#(
  parameter int FRAMES_PER_STEP = DEFAULT_RATE,
  parameter int NUM_PATTERNS    = 4,
  parameter int BAR_STEPS       = 16
) (
  input  logic                      PixelClk,
  input  logic                      nRST,
  input  logic                      LCD_VSYNC,
  lcd_pattern_sched_if.slave        cfg,
  output logic [1:0]                pattern_sel,
  output logic [15:0]               bar_offset,
  output logic                      blank,
`ifdef LCD_SCHED_FRAME_CNT_EN
  output logic [15:0]               frame_count,
`endif
  output logic                      frame_tick
);

  localparam logic [1:0]  PAT_MAX    = 2'(NUM_PATTERNS - 1);
  localparam logic [15:0] BAR_MAX    = 16'(BAR_STEPS - 1);
  localparam logic [7:0]  RESET_RATE = 8'(FRAMES_PER_STEP);

  sched_state_t state_reg;
  cfg_mode_t    mode_reg;
  logic [7:0]   rate_reg;
  logic [7:0]   frame_cnt_reg;
  logic [1:0]   pattern_sel_reg;
  logic [15:0]  bar_offset_reg;
  logic         blank_reg;
  logic         cfg_ready_reg;

  // Shadow copy of an accepted configuration awaiting the next frame start.
  cfg_mode_t    shd_mode_reg;
  logic [1:0]   shd_pattern_reg;
  logic [7:0]   shd_rate_reg;

  logic         accept;

  lcd_frame_tick u_frame_tick (
    .PixelClk   (PixelClk),
    .nRST       (nRST),
    .LCD_VSYNC  (LCD_VSYNC),
`ifdef LCD_SCHED_FRAME_CNT_EN
    .frame_count(frame_count),
`endif
    .frame_tick (frame_tick)
  );

  assign accept = cfg.cfg_valid & cfg_ready_reg;

  // Scheduler FSM: frame counting, step actions and config shadow/apply.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state_reg       <= IDLE;
      mode_reg        <= AUTO;
      rate_reg        <= RESET_RATE;
      frame_cnt_reg   <= 8'd0;
      pattern_sel_reg <= 2'd0;
      bar_offset_reg  <= 16'd0;
      blank_reg       <= 1'b0;
      cfg_ready_reg   <= 1'b0;
      shd_mode_reg    <= AUTO;
      shd_pattern_reg <= 2'd0;
      shd_rate_reg    <= 8'd0;
    end else begin
      cfg_ready_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          // The first frame start only arms counting; it is not counted.
          if (accept) begin
            shd_mode_reg    <= cfg_mode_t'(cfg.cfg_mode);
            shd_pattern_reg <= cfg.cfg_pattern;
            shd_rate_reg    <= cfg.cfg_rate;
            cfg_ready_reg   <= 1'b0;
            state_reg       <= PEND;
          end else if (frame_tick) begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (frame_tick) begin
            if (frame_cnt_reg == rate_reg - 8'd1) begin
              frame_cnt_reg <= 8'd0;
              case (mode_reg)
                AUTO:    pattern_sel_reg <= (pattern_sel_reg == PAT_MAX) ? 2'd0 : pattern_sel_reg + 2'd1;
                SCROLL:  bar_offset_reg  <= (bar_offset_reg == BAR_MAX) ? 16'd0 : bar_offset_reg + 16'd1;
                default: ;
              endcase
            end else begin
              frame_cnt_reg <= frame_cnt_reg + 8'd1;
            end
          end
          // A step due on the accept cycle still happens above.
          if (accept) begin
            shd_mode_reg    <= cfg_mode_t'(cfg.cfg_mode);
            shd_pattern_reg <= cfg.cfg_pattern;
            shd_rate_reg    <= cfg.cfg_rate;
            cfg_ready_reg   <= 1'b0;
            state_reg       <= PEND;
          end
        end
        PEND: begin
          // Counting is frozen; the shadow config lands on the next frame start.
          cfg_ready_reg <= 1'b0;
          if (frame_tick) begin
            mode_reg        <= shd_mode_reg;
            rate_reg        <= norm_rate(shd_rate_reg);
            pattern_sel_reg <= shd_pattern_reg;
            bar_offset_reg  <= 16'd0;
            frame_cnt_reg   <= 8'd0;
            blank_reg       <= (shd_mode_reg == BLANK);
            cfg_ready_reg   <= 1'b1;
            state_reg       <= RUN;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign cfg.cfg_ready = cfg_ready_reg;
  assign pattern_sel   = pattern_sel_reg;
  assign bar_offset    = bar_offset_reg;
  assign blank         = blank_reg;

endmodule

// File: tb/tb_lcd_pattern_sched.sv
// tb_lcd_pattern_sched: directed and randomized frame sequences checked
// against a frame-level reference model of the scheduler.
module tb_lcd_pattern_sched;

  localparam int NP    = 4;
  localparam int BS    = 16;
  localparam int RATE0 = 2;

  localparam int M_AUTO   = 0;
  localparam int M_FIXED  = 1;
  localparam int M_SCROLL = 2;
  localparam int M_BLANK  = 3;

  logic        PixelClk = 1'b0;
  logic        nRST     = 1'b0;
  logic        LCD_VSYNC = 1'b0;
  logic [1:0]  pattern_sel;
  logic [15:0] bar_offset;
  logic        blank;
  logic        frame_tick;
`ifdef LCD_SCHED_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  lcd_pattern_sched_if cfg_if ();

  lcd_pattern_sched #(
    .FRAMES_PER_STEP(RATE0),
    .NUM_PATTERNS   (NP),
    .BAR_STEPS      (BS)
  ) dut (
    .PixelClk   (PixelClk),
    .nRST       (nRST),
    .LCD_VSYNC  (LCD_VSYNC),
    .cfg        (cfg_if),
    .pattern_sel(pattern_sel),
    .bar_offset (bar_offset),
    .blank      (blank),
`ifdef LCD_SCHED_FRAME_CNT_EN
    .frame_count(frame_count),
`endif
    .frame_tick (frame_tick)
  );

  always #5 PixelClk = ~PixelClk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: frame-level view of the scheduler.
  bit m_started, m_pending;
  int m_mode, m_rate, m_cnt, m_pat, m_bar, m_blank, m_frames;
  int p_mode, p_pat, p_rate;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_edge();
    @(posedge PixelClk);
    #1;
  endtask

  task automatic model_reset();
    m_started = 0; m_pending = 0;
    m_mode = M_AUTO; m_rate = RATE0; m_cnt = 0;
    m_pat = 0; m_bar = 0; m_blank = 0; m_frames = 0;
  endtask

  task automatic model_accept(input int mode, input int pat, input int rate);
    m_pending = 1; p_mode = mode; p_pat = pat; p_rate = rate;
  endtask

  task automatic model_tick();
    m_frames = (m_frames + 1) % 65536;
    if (m_pending) begin
      m_pending = 0; m_started = 1;
      m_mode = p_mode; m_rate = (p_rate == 0) ? 1 : p_rate;
      m_pat = p_pat; m_bar = 0; m_cnt = 0; m_blank = (p_mode == M_BLANK);
    end else if (!m_started) begin
      m_started = 1;
    end else begin
      m_cnt++;
      if (m_cnt >= m_rate) begin
        m_cnt = 0;
        if (m_mode == M_AUTO)   m_pat = (m_pat + 1) % NP;
        if (m_mode == M_SCROLL) m_bar = (m_bar + 1) % BS;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".pattern_sel"}, 32'(pattern_sel), 32'(m_pat));
    chk({tag, ".bar_offset"},  32'(bar_offset),  32'(m_bar));
    chk({tag, ".blank"},       32'(blank),       32'(m_blank));
    chk({tag, ".cfg_ready"},   32'(cfg_if.cfg_ready), 32'(!m_pending));
`ifdef LCD_SCHED_FRAME_CNT_EN
    chk({tag, ".frame_count"}, 32'(frame_count), 32'(m_frames));
`endif
  endtask

  // One frame: VSYNC high for a random time, then falling edge. Optionally
  // presents a config in the frame_tick cycle so it coincides with the tick.
  task automatic do_frame(input bit with_cfg, input int mode, input int pat, input int rate);
    LCD_VSYNC = 1'b1;
    repeat ($urandom_range(2, 4)) tick_edge();
    LCD_VSYNC = 1'b0;
    tick_edge();
    chk("tick_high", 32'(frame_tick), 32'd1);
    if (with_cfg) begin
      chk("ready_at_tick", 32'(cfg_if.cfg_ready), 32'(!m_pending));
      cfg_if.cfg_valid   = 1'b1;
      cfg_if.cfg_mode    = 2'(mode);
      cfg_if.cfg_pattern = 2'(pat);
      cfg_if.cfg_rate    = 8'(rate);
    end
    tick_edge();
    model_tick();
    if (with_cfg) begin
      model_accept(mode, pat, rate);
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_rate  = 8'($urandom);
    end
    chk("tick_one_cycle", 32'(frame_tick), 32'd0);
    check_outputs("frame");
    $display("frame %0d: cfg_at_tick=%0d pattern_sel=%0d bar_offset=%0d blank=%0d",
             m_frames, with_cfg, pattern_sel, bar_offset, blank);
    tick_edge();
  endtask

  // Config handshake away from any frame start.
  task automatic send_cfg(input int mode, input int pat, input int rate);
    chk("ready_before_cfg", 32'(cfg_if.cfg_ready), 32'(!m_pending));
    if (!m_pending) begin
      cfg_if.cfg_valid   = 1'b1;
      cfg_if.cfg_mode    = 2'(mode);
      cfg_if.cfg_pattern = 2'(pat);
      cfg_if.cfg_rate    = 8'(rate);
      tick_edge();
      model_accept(mode, pat, rate);
      cfg_if.cfg_valid   = 1'b0;
      cfg_if.cfg_mode    = 2'($urandom);
      cfg_if.cfg_pattern = 2'($urandom);
      chk("ready_after_accept", 32'(cfg_if.cfg_ready), 32'd0);
      $display("cfg accepted: mode=%0d pattern=%0d rate=%0d", mode, pat, rate);
      tick_edge();
    end
  endtask

  initial begin
    cfg_if.cfg_valid   = 1'b0;
    cfg_if.cfg_mode    = 2'd0;
    cfg_if.cfg_pattern = 2'd0;
    cfg_if.cfg_rate    = 8'd0;
    model_reset();

    // Reset with VSYNC held low through release.
    repeat (3) tick_edge();
    chk("rst.cfg_ready", 32'(cfg_if.cfg_ready), 32'd0);
    chk("rst.frame_tick", 32'(frame_tick), 32'd0);
    nRST = 1'b1;
    tick_edge();
    tick_edge();
    chk("rst.ready_2nd_edge", 32'(cfg_if.cfg_ready), 32'd1);
    repeat (4) begin
      tick_edge();
      chk("rst.no_tick", 32'(frame_tick), 32'd0);
    end
    check_outputs("rst");

    // Default AUTO at rate 2 for 7 frames.
    repeat (7) do_frame(0, 0, 0, 0);
    chk("auto7.pattern_sel", 32'(pattern_sel), 32'd3);

    // SCROLL at rate 1: 18 steps after the apply frame.
    send_cfg(M_SCROLL, 0, 1);
    do_frame(0, 0, 0, 0);
    repeat (18) do_frame(0, 0, 0, 0);
    chk("scroll18.bar_offset", 32'(bar_offset), 32'd2);

    // FIXED pattern 2 accepted on the frame_tick cycle.
    do_frame(1, M_FIXED, 2, 5);
    chk("fixed.not_yet", 32'(pattern_sel), 32'd0);
    do_frame(0, 0, 0, 0);
    chk("fixed.applied", 32'(pattern_sel), 32'd2);
    repeat (10) do_frame(0, 0, 0, 0);
    chk("fixed.held", 32'(pattern_sel), 32'd2);

    // Rate 0 in AUTO steps every frame.
    send_cfg(M_AUTO, 1, 0);
    do_frame(0, 0, 0, 0);
    repeat (3) do_frame(0, 0, 0, 0);
    chk("rate0.pattern_sel", 32'(pattern_sel), 32'd0);

    // BLANK keeps cfg_pattern and forces blank.
    send_cfg(M_BLANK, 3, 2);
    do_frame(0, 0, 0, 0);
    chk("blank.on", 32'(blank), 32'd1);
    repeat (3) do_frame(0, 0, 0, 0);

    // Randomized frames and configs.
    for (int i = 0; i < 30; i++) begin
      int sel;
      sel = int'($urandom_range(0, 3));
      if (sel == 0 && !m_pending)
        send_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      if (sel == 1 && !m_pending)
        do_frame(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else
        do_frame(0, 0, 0, 0);
    end

    // Reset while a config is pending.
    send_cfg(M_AUTO, 2, 9);
    do_frame(0, 0, 0, 0);
    send_cfg(M_SCROLL, 1, 3);
    nRST = 1'b0;
    #2;
    model_reset();
    chk("rstpend.pattern_sel", 32'(pattern_sel), 32'd0);
    chk("rstpend.bar_offset",  32'(bar_offset),  32'd0);
    chk("rstpend.blank",       32'(blank),       32'd0);
    chk("rstpend.cfg_ready",   32'(cfg_if.cfg_ready), 32'd0);
    chk("rstpend.frame_tick",  32'(frame_tick),  32'd0);
    tick_edge();
    nRST = 1'b1;
    tick_edge();
    repeat (3) do_frame(0, 0, 0, 0);
    chk("rstpend.default_cfg", 32'(pattern_sel), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
